// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: round-robin owner of the shared bus; req[NSRC] in, registered one-hot grant, bus_sel code, bus_valid and hold_cnt out; lock keeps the owner for at most MAXHOLD cycles; clr is an async active-low reset
module bus_source_arbiter #(
  parameter int NSRC    = 24,
  parameter int SELW    = 5,
  parameter int MAXHOLD = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NSRC-1:0] req,
  input  logic            lock,
  output logic [NSRC-1:0] grant,
  output logic [SELW-1:0] bus_sel,
  output logic            bus_valid,
  output logic [2:0]      hold_cnt
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state, state_d;
  logic [SELW-1:0] last, last_d, sel_d, base, win;
  logic [NSRC-1:0] grant_d;
  logic [2:0] hold_d;
  logic found, keep;
  int idx;
  always_comb begin
    base = state == OWNED ? bus_sel : last;
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int i = 1; i <= NSRC; i++) begin
      idx = int'(base) + i;
      idx = idx >= NSRC ? idx - NSRC : idx;
      if (!found && req[SELW'(idx)]) begin
        found = 1'b1;
        win = SELW'(idx);
      end
    end
  end
  assign keep = state == OWNED && req[bus_sel] && lock && hold_cnt < 3'(MAXHOLD);
  always_comb begin
    state_d = found ? OWNED : IDLE;
    last_d = state == OWNED ? bus_sel : last;
    grant_d = found ? NSRC'(1) << win : '0;
    sel_d = found ? win : '0;
    hold_d = found ? 3'd1 : 3'd0;
    if (keep) begin
      state_d = state;
      last_d = last;
      grant_d = grant;
      sel_d = bus_sel;
      hold_d = hold_cnt + 3'd1;
    end
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      last <= SELW'(NSRC - 1);
      grant <= '0;
      bus_sel <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_d;
      last <= last_d;
      grant <= grant_d;
      bus_sel <= sel_d;
      hold_cnt <= hold_d;
    end
  end
  assign bus_valid = |grant;
endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb_bus_source_arbiter: directed self-checking bench for bus_source_arbiter
module tb_bus_source_arbiter;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [23:0] req = '0;
  logic lock = 1'b0;
  logic [23:0] grant;
  logic [4:0] bus_sel;
  logic bus_valid;
  logic [2:0] hold_cnt;
  int passed = 0;
  int total = 0;
  bus_source_arbiter dut (
    .clk(clk), .clr(clr), .req(req), .lock(lock),
    .grant(grant), .bus_sel(bus_sel), .bus_valid(bus_valid), .hold_cnt(hold_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic owner(input string tag, input int s, input int h);
    chk({tag, " grant"}, 32'(grant), 32'(24'd1 << s));
    chk({tag, " sel"}, 32'(bus_sel), 32'(s));
    chk({tag, " valid"}, 32'(bus_valid), 32'd1);
    chk({tag, " hold"}, 32'(hold_cnt), 32'(h));
  endtask
  task automatic idle(input string tag);
    chk({tag, " grant"}, 32'(grant), 32'd0);
    chk({tag, " sel"}, 32'(bus_sel), 32'd0);
    chk({tag, " valid"}, 32'(bus_valid), 32'd0);
    chk({tag, " hold"}, 32'(hold_cnt), 32'd0);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    @(negedge clk);
    req = '0;
    lock = 1'b0;
    clr = 1'b0;
    #2;
    idle("reset");
    clr = 1'b1;
  endtask
  initial begin
    do_reset();
    step();
    idle("idle no req");
    req = 24'h000001;
    for (int k = 0; k < 4; k++) begin
      step();
      owner("r0 solo", 0, 1);
    end
    do_reset();
    req = (24'd1 << 20) | (24'd1 << 21);
    for (int k = 0; k < 4; k++) begin
      step();
      owner("pc/mdr alt", (k % 2 == 0) ? 20 : 21, 1);
    end
    do_reset();
    req = (24'd1 << 16) | (24'd1 << 3);
    lock = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      owner("lock r3", 3, k + 1);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      owner("lock hi", 16, k + 1);
    end
    step();
    owner("lock r3 again", 3, 1);
    do_reset();
    req = (24'd1 << 5) | (24'd1 << 22);
    lock = 1'b1;
    step();
    owner("own r5", 5, 1);
    step();
    owner("own r5 hold", 5, 2);
    req = 24'd1 << 22;
    step();
    owner("drop r5", 22, 1);
    do_reset();
    req = 24'd1 << 23;
    step();
    owner("own c", 23, 1);
    @(negedge clk);
    clr = 1'b0;
    #1;
    idle("async clr");
    #1;
    clr = 1'b1;
    req = 24'hFFFFFF;
    step();
    owner("after clr", 0, 1);
    do_reset();
    req = 24'hFFFFFF;
    for (int k = 0; k < 25; k++) begin
      step();
      owner("all rr", k % 24, 1);
      chk("onehot", 32'($onehot(grant)), 32'd1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
